pll_lock_supervisor: RTL

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_lock_supervisor.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies lock through a
// synchronizer and a stability window, releases the core reset, retries on
// lock timeout and parks in FAULT once the retry allowance is used up.
//
// state  | meaning
// -------+----------------------------------------------------------------
// RST    | pll_rst asserted for PLL_RST_CYCLES, core held in reset
// WAIT   | PLL released, waiting up to LOCK_WAIT_CYCLES for lock
// STABLE | lock seen, must stay locked for STABLE_CYCLES in a row
// RUN    | core released; any lock drop restarts the sequence
// FAULT  | retries exhausted, PLL and core held until fault_clr
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES   = 16,
    parameter int LOCK_WAIT_CYCLES = 1024,
    parameter int STABLE_CYCLES    = 256,
    parameter int MAX_RETRIES      = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       fault_clr,
    output logic       pll_rst,
    output logic       core_rst_n,
    output logic       running,
    output logic       fault,
    output logic       lock_lost,
    output logic [3:0] retry_cnt
);

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    // Terminal counts of the shared up-counter (counter starts at 0 on entry).
    localparam logic [15:0] RST_LAST    = 16'(PLL_RST_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST   = 16'(LOCK_WAIT_CYCLES - 1);
    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [3:0]  MAX_R       = 4'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic        sync1_q, sync1_d;
    logic        lk_q, lk_d;
    logic        pll_rst_q, pll_rst_d;
    logic        core_rst_n_q, core_rst_n_d;
    logic        running_q, running_d;
    logic        fault_q, fault_d;
    logic        lock_lost_q, lock_lost_d;

    // Next-state, counter, retry and output decode; outputs follow the next state
    // so they change on the same edge as the state register.
    always_comb begin
        sync1_d     = pll_locked;
        lk_d        = sync1_q;
        state_d     = state_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;
        cnt_d       = cnt_q + 16'd1;

        case (state_q)
            ST_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lk_q) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == WAIT_LAST) begin
                    if (retry_q == MAX_R) begin
                        state_d = ST_FAULT;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = ST_RST;
                    end
                end
            end
            ST_STABLE: begin
                if (!lk_q) begin
                    state_d = ST_WAIT;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    retry_d = 4'd0;
                end
            end
            ST_RUN: begin
                if (!lk_q) begin
                    state_d     = ST_RST;
                    lock_lost_d = 1'b1;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d = ST_RST;
                    retry_d = 4'd0;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase

        // RUN and FAULT have no timing of their own, so the counter rests at 0 there.
        if ((state_d != state_q) || (state_q == ST_RUN) || (state_q == ST_FAULT)) begin
            cnt_d = 16'd0;
        end

        pll_rst_d    = (state_d == ST_RST) || (state_d == ST_FAULT);
        core_rst_n_d = (state_d == ST_RUN);
        running_d    = (state_d == ST_RUN);
        fault_d      = (state_d == ST_FAULT);
    end

    // Single register bank for the synchronizer, FSM, counter and outputs.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            lk_q         <= 1'b0;
            state_q      <= ST_RST;
            cnt_q        <= 16'd0;
            retry_q      <= 4'd0;
            pll_rst_q    <= 1'b1;
            core_rst_n_q <= 1'b0;
            running_q    <= 1'b0;
            fault_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            lk_q         <= lk_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            pll_rst_q    <= pll_rst_d;
            core_rst_n_q <= core_rst_n_d;
            running_q    <= running_d;
            fault_q      <= fault_d;
            lock_lost_q  <= lock_lost_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign core_rst_n = core_rst_n_q;
    assign running    = running_q;
    assign fault      = fault_q;
    assign lock_lost  = lock_lost_q;
    assign retry_cnt  = retry_q;

endmodule
